// File: rtl/iter_ctrl_pkg.sv
// Shared encodings for the iteration sequencer.
package iter_ctrl_pkg;

  // 2-bit state encoding, kept as plain constants so legacy code can compare
  // against raw values.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/iter_ctrl.sv
// Iteration sequencer: load strobe, len_q step enables with index/last flag,
// then a done pulse. Supports abort, auto-repeat, restart policy and
// back-to-back starts. All outputs decode from registered state only.
module iter_ctrl
  import iter_ctrl_pkg::*;
#(
  parameter int CNT_W            = 4,
  parameter bit RESTART_ON_START = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  input  logic             auto_rpt,
  output logic             load,
  output logic             en,
  output logic [CNT_W-1:0] idx,
  output logic             last,
  output logic             done,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             rpt_q, rpt_d;
  logic             at_last;
  logic             restart;

  // len_q==0 never reaches RUN, but guard the compare so len_q-1 can't
  // alias to all-ones.
  assign at_last = (state_q == S_RUN) && (len_q != '0) &&
                   (idx_q == len_q - CNT_W'(1));
  assign restart = start && RESTART_ON_START;

  // Next-state, counter and latch logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      rpt_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_d   = len;
            rpt_d   = auto_rpt;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          idx_d = '0;
          if (restart) begin
            len_d   = len;
            rpt_d   = auto_rpt;
            state_d = S_LOAD;
          end else if (len_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (restart) begin
            len_d   = len;
            rpt_d   = auto_rpt;
            idx_d   = '0;
            state_d = S_LOAD;
          end else if (at_last) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        default: begin // S_DONE
          idx_d = '0;
          if (start) begin
            len_d   = len;
            rpt_d   = auto_rpt;
            state_d = S_LOAD;
          end else if (rpt_q) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rpt_q   <= rpt_d;
    end
  end

  // idx_q is held at 0 outside RUN, so it drives idx directly.
  assign load = (state_q == S_LOAD);
  assign en   = (state_q == S_RUN);
  assign idx  = idx_q;
  assign last = at_last;
  assign done = (state_q == S_DONE);
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_iter_ctrl.sv
// Bench for iter_ctrl: two instances (restart policy 0 and 1) share stimulus
// and are each compared to a cycle-position reference model, plus a table of
// hand-written vectors and targeted corner-case sequences.
module tb_iter_ctrl;
  localparam int W  = 4;
  localparam int OW = W + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, auto_rpt = 1'b0;
  logic [W-1:0] len = '0;
  logic [1:0] load, en, last, done, busy;
  logic [1:0][W-1:0] idx_o;

  int errors = 0;
  int checks = 0;

  // Reference model: position since the load cycle (-1 = idle).
  // pos 0 = load, 1..L = step enables, L+1 = done.
  int m_pos[2];
  int m_len[2];
  bit m_rpt[2];

  always #5 clk = ~clk;

  iter_ctrl #(.CNT_W(W), .RESTART_ON_START(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .auto_rpt(auto_rpt), .load(load[0]), .en(en[0]), .idx(idx_o[0]),
    .last(last[0]), .done(done[0]), .busy(busy[0]));

  iter_ctrl #(.CNT_W(W), .RESTART_ON_START(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .auto_rpt(auto_rpt), .load(load[1]), .en(en[1]), .idx(idx_o[1]),
    .last(last[1]), .done(done[1]), .busy(busy[1]));

  function automatic logic [OW-1:0] pk(bit ld, bit e, int ix, bit ls, bit dn, bit bz);
    logic [W-1:0] i4;
    i4 = W'(ix);
    return {ld, e, i4, ls, dn, bz};
  endfunction

  function automatic logic [OW-1:0] actual(int i);
    return {load[i], en[i], idx_o[i], last[i], done[i], busy[i]};
  endfunction

  function automatic logic [OW-1:0] mexp(int i);
    int p, l;
    bit e;
    p = m_pos[i];
    l = m_len[i];
    e = (p >= 1) && (p <= l);
    return pk(p == 0, e, e ? p - 1 : 0, e && (p == l), p == l + 1, p >= 0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1;
      m_len[i] = 0;
      m_rpt[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(int i, bit rs);
    bit act, dn, mid;
    act = m_pos[i] >= 0;
    dn  = m_pos[i] == m_len[i] + 1;
    mid = act && !dn;
    if (abort) begin
      m_pos[i] = -1;
      m_rpt[i] = 1'b0;
    end else if (start && (!act || dn || (mid && rs))) begin
      m_len[i] = int'(len);
      m_rpt[i] = auto_rpt;
      m_pos[i] = 0;
    end else if (dn) begin
      m_pos[i] = m_rpt[i] ? 0 : -1;
    end else if (act) begin
      m_pos[i] = m_pos[i] + 1;
    end
  endfunction

  task automatic chk(input string name, input logic [OW-1:0] act_v, input logic [OW-1:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got {ld,en,idx,last,done,busy}=%b want %b", name, act_v, exp_v);
    end
  endtask

  task automatic chk_int(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act_v, exp_v);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at negedge.
  task automatic cyc(input bit s, input bit a, input int l, input bit r);
    start = s; abort = a; len = W'(l); auto_rpt = r;
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(negedge clk);
    chk("model0", actual(0), mexp(0));
    chk("model1", actual(1), mexp(1));
  endtask

  typedef struct {
    bit           s;
    bit           a;
    int           l;
    bit           r;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n_done0, n_done1, n_en0, n_en1, max_idx, guard;

    // Basic len=5 run followed by a zero-length run.
    tbl[0]  = '{1, 0, 5, 0, pk(1, 0, 0, 0, 0, 1)};
    tbl[1]  = '{0, 0, 0, 0, pk(0, 1, 0, 0, 0, 1)};
    tbl[2]  = '{0, 0, 0, 0, pk(0, 1, 1, 0, 0, 1)};
    tbl[3]  = '{0, 0, 0, 0, pk(0, 1, 2, 0, 0, 1)};
    tbl[4]  = '{0, 0, 0, 0, pk(0, 1, 3, 0, 0, 1)};
    tbl[5]  = '{0, 0, 0, 0, pk(0, 1, 4, 1, 0, 1)};
    tbl[6]  = '{0, 0, 0, 0, pk(0, 0, 0, 0, 1, 1)};
    tbl[7]  = '{0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1, 0, 0, 0, pk(1, 0, 0, 0, 0, 1)};
    tbl[9]  = '{0, 0, 0, 0, pk(0, 0, 0, 0, 1, 1)};
    tbl[10] = '{0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0)};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset0", actual(0), '0);
    chk("reset1", actual(1), '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].s, tbl[k].a, tbl[k].l, tbl[k].r);
      chk($sformatf("tbl%0d_d0", k), actual(0), tbl[k].exp);
      chk($sformatf("tbl%0d_d1", k), actual(1), tbl[k].exp);
    end

    // Auto-repeat len=3: done every 5 cycles, then abort in RUN.
    cyc(1, 0, 3, 1);
    n_done0 = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(0, 0, 0, 0);
      n_done0 += int'(done[0]);
    end
    chk_int("rpt_done_count", n_done0, 3);
    guard = 0;
    while (!en[0] && guard < 10) begin cyc(0, 0, 0, 0); guard++; end
    chk_int("rpt_reach_run", int'(en[0]), 1);
    cyc(0, 1, 0, 0);
    chk_int("abort_idle", int'(busy[0]), 0);
    n_done0 = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      n_done0 += int'(done[0]) + int'(done[1]);
    end
    chk_int("abort_no_done", n_done0, 0);

    // Back-to-back: start len=7 in the DONE cycle of a len=2 run.
    cyc(1, 0, 2, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_int("b2b_done_seen", int'(done[0]), 1);
    cyc(1, 0, 7, 0);
    chk_int("b2b_load", int'(load[0]), 1);
    n_en0 = 0; n_done0 = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      n_en0 += int'(en[0]);
      n_done0 += int'(done[0]);
    end
    chk_int("b2b_en_count", n_en0, 7);
    chk_int("b2b_done_count", n_done0, 1);

    // Restart policy: start len=4 while at RUN idx=2 of a len=6 run.
    cyc(1, 0, 6, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_int("rs_at_idx2", int'(idx_o[0]), 2);
    n_en0 = 0; n_en1 = 0; n_done0 = 0; n_done1 = 0;
    cyc(1, 0, 4, 0);
    chk_int("rs1_load", int'(load[1]), 1);
    n_en0 += int'(en[0]);
    for (int k = 0; k < 11; k++) begin
      cyc(0, 0, 0, 0);
      n_en0 += int'(en[0]);   n_en1 += int'(en[1]);
      n_done0 += int'(done[0]); n_done1 += int'(done[1]);
    end
    chk_int("rs0_en_rest", n_en0, 3);
    chk_int("rs1_en_fresh", n_en1, 4);
    chk_int("rs0_done", n_done0, 1);
    chk_int("rs1_done", n_done1, 1);

    // Maximum length: 15 steps, idx tops out at 14, no wrap.
    cyc(1, 0, 15, 0);
    n_en0 = 0; max_idx = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0);
      n_en0 += int'(en[0]);
      if (en[0] && int'(idx_o[0]) > max_idx) max_idx = int'(idx_o[0]);
    end
    chk_int("max_en_count", n_en0, 15);
    chk_int("max_idx", max_idx, 14);

    // Asynchronous reset at idx=8.
    cyc(1, 0, 15, 0);
    guard = 0;
    while (!(en[0] && idx_o[0] == W'(8)) && guard < 20) begin cyc(0, 0, 0, 0); guard++; end
    chk_int("rst_reach_idx8", int'(idx_o[0]), 8);
    rst_n = 1'b0;
    #1;
    chk("async_rst0", actual(0), '0);
    chk("async_rst1", actual(1), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(5, 0) == 0, $urandom_range(19, 0) == 0,
          int'($urandom_range(15, 0)), $urandom_range(2, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
